// File: rtl/hm_pkg.sv
// Shared widths, sequencer state encoding and the pass-2 padding helper
// for the hash-module block path.
package hm_pkg;

  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 256;
  localparam int unsigned NONCE_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    SEND1,
    WAIT1,
    SEND2,
    WAIT2,
    DONE
  } hm_seq_state_t;

  // Second-pass block: digest, SHA-256 end marker, zero fill, 256-bit length.
  function automatic logic [BLOCK_W-1:0] hm_pad_digest(input logic [DIGEST_W-1:0] digest);
    return {digest, 1'b1, 191'b0, 64'd256};
  endfunction

endpackage

// File: rtl/hm_nonce_gen.sv
// Nonce walker for one module's slice: loads base+MODULE_NUM, strides by
// NUM_MODULES per advance, and flags the last iteration of the job.
module hm_nonce_gen
  import hm_pkg::*;
#(
  parameter int unsigned MODULE_NUM  = 0,
  parameter int unsigned NUM_MODULES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  input  logic [NONCE_W-1:0] base,
  input  logic [NONCE_W-1:0] count,
  output logic [NONCE_W-1:0] nonce,
  output logic               last
);

  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] iter_q,  iter_d;
  logic [NONCE_W-1:0] count_q, count_d;

  assign last  = (iter_q + 1'b1) == count_q;
  assign nonce = nonce_q;

  always_comb begin
    nonce_d = nonce_q;
    iter_d  = iter_q;
    count_d = count_q;
    if (load) begin
      nonce_d = base + NONCE_W'(MODULE_NUM);
      iter_d  = '0;
      count_d = count;
    end else if (advance) begin
      iter_d = iter_q + 1'b1;
      if (!last) begin
        nonce_d = nonce_q + NONCE_W'(NUM_MODULES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nonce_q <= '0;
      iter_q  <= '0;
      count_q <= '0;
    end else begin
      nonce_q <= nonce_d;
      iter_q  <= iter_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hm_block_sequencer.sv
// Per-job block sequencer: for each nonce in this module's slice, offers the
// nonce-stamped header block, then the padded first-pass digest, to one core.
module hm_block_sequencer
  import hm_pkg::*;
#(
  parameter int unsigned MODULE_NUM  = 0,
  parameter int unsigned NUM_MODULES = 1,
  parameter int unsigned NONCE_LSB   = 384
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [BLOCK_W-1:0]  header_tail,
  input  logic [NONCE_W-1:0]  start_nonce,
  input  logic [NONCE_W-1:0]  nonce_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  out_data,
  output logic                out_pass,
  output logic [NONCE_W-1:0]  out_nonce,
  input  logic                hash_done,
  input  logic [DIGEST_W-1:0] hash_in,
  output logic                busy,
  output logic                done
);

  hm_seq_state_t       state_q, state_d;
  logic [BLOCK_W-1:0]  header_q, header_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;
  logic                busy_q, busy_d;

  logic               load;
  logic               advance;
  logic               last;
  logic [NONCE_W-1:0] cur_nonce;

  assign load    = (state_q == IDLE)  && start     && !abort;
  assign advance = (state_q == WAIT2) && hash_done && !abort;

  hm_nonce_gen #(
    .MODULE_NUM  (MODULE_NUM),
    .NUM_MODULES (NUM_MODULES)
  ) u_nonce_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .base    (start_nonce),
    .count   (nonce_count),
    .nonce   (cur_nonce),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      header_q <= '0;
      digest_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      header_q <= header_d;
      digest_q <= digest_d;
      busy_q   <= busy_d;
    end
  end

  // Abort is applied last so it overrides every transition, including start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = (nonce_count == '0) ? DONE : SEND1;
      SEND1:   if (out_ready) state_d = WAIT1;
      WAIT1:   if (hash_done) state_d = SEND2;
      SEND2:   if (out_ready) state_d = WAIT2;
      WAIT2:   if (hash_done) state_d = last ? DONE : SEND1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    header_d = header_q;
    digest_d = digest_q;
    if (load) begin
      header_d = header_tail;
    end
    if ((state_q == WAIT1) && hash_done && !abort) begin
      digest_d = hash_in;
    end
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    out_valid = 1'b0;
    out_pass  = 1'b0;
    out_data  = '0;
    case (state_q)
      SEND1: begin
        out_valid = 1'b1;
        out_data  = header_q;
        out_data[NONCE_LSB +: NONCE_W] = cur_nonce;
      end
      SEND2: begin
        out_valid = 1'b1;
        out_pass  = 1'b1;
        out_data  = hm_pad_digest(digest_q);
      end
      default: ;
    endcase
  end

  assign done      = (state_q == DONE);
  assign busy      = busy_q;
  assign out_nonce = cur_nonce;

endmodule
